// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by if_fetch and if_pc_reg.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with redirect, increment and hold.
// Low two bits are forced to zero on every load.
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir,
  input  logic [29:0] redir_word,
  input  logic        inc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + PC_INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= {RESET_PC[31:2], 2'b00};
    end else if (redir) begin
      pc <= {redir_word, 2'b00};
    end else if (inc) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: BOOT/FETCH/STALL control plus
// the IF/ID output register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcp4,
  output logic [31:0] ins,
  output logic        out_valid,
  output logic        misalign
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redir;
  logic        done;
  logic        hold;
  logic        fetch_go;
  logic        stall_go;
  logic        cap;
  logic        clr;

  // Redirects are ignored until the first fetch cycle.
  assign redir    = redirect_en && (state != BOOT);
  assign done     = imem_req && imem_ready;
  assign hold     = stall && out_valid;
  assign fetch_go = !redir && (state == FETCH) && !hold;
  assign stall_go = !redir && (state == STALL) && !stall;

  assign imem_addr = pc;

  if_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .redir     (redir),
    .redir_word(redirect_pc[31:2]),
    .inc       (cap),
    .pc        (pc),
    .pc_plus4  (pc_plus4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   state_nxt = (!redir && hold) ? STALL : FETCH;
      STALL:   state_nxt = (!redir && stall) ? STALL : FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH);
    cap      = 1'b0;
    clr      = 1'b0;
    unique case (1'b1)
      redir:             clr = 1'b1;
      fetch_go && done:  cap = 1'b1;
      fetch_go && !done: clr = 1'b1;
      stall_go:          clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins       <= NOP;
      pcp4      <= '0;
      out_valid <= 1'b0;
    end else if (cap) begin
      ins       <= imem_rdata;
      pcp4      <= pc_plus4;
      out_valid <= 1'b1;
    end else if (clr) begin
      ins       <= NOP;
      pcp4      <= '0;
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (redir && (redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sequential fetch, wait states,
// stall, redirect, BOOT-redirect, PC wrap and async reset.
module tb_if_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_ready;

  logic        req1, req2;
  logic [31:0] addr1, addr2;
  logic [31:0] rdata1, rdata2;
  logic [31:0] pcp41, pcp42;
  logic [31:0] ins1, ins2;
  logic        ov1, ov2;
  logic        mis1, mis2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata1 = addr1 ^ K;
  assign rdata2 = addr2 ^ K;

  if_fetch u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req   (req1),
    .imem_addr  (addr1),
    .imem_ready (imem_ready),
    .imem_rdata (rdata1),
    .pcp4       (pcp41),
    .ins        (ins1),
    .out_valid  (ov1),
    .misalign   (mis1)
  );

  if_fetch #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .clk        (clk),
    .rst_n      (rst2_n),
    .stall      (stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req   (req2),
    .imem_addr  (addr2),
    .imem_ready (imem_ready),
    .imem_rdata (rdata2),
    .pcp4       (pcp42),
    .ins        (ins2),
    .out_valid  (ov2),
    .misalign   (mis2)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic req,
                      input logic [31:0] addr, input logic v,
                      input logic [31:0] i, input logic [31:0] p);
    chk({tag, ".req"}, {31'b0, req1}, {31'b0, req});
    chk({tag, ".addr"}, addr1, addr);
    chk({tag, ".ov"}, {31'b0, ov1}, {31'b0, v});
    chk({tag, ".ins"}, ins1, i);
    chk({tag, ".pcp4"}, pcp41, p);
  endtask

  initial begin
    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b1;
    #3;
    chk1("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst.mis", {31'b0, mis1}, 32'h0);
    tick();
    rst_n = 1'b1;

    // sequential fetch
    tick();
    chk1("boot", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk1("f0", 1'b1, 32'h4, 1'b1, 32'h0 ^ K, 32'h4);
    tick();
    chk1("f4", 1'b1, 32'h8, 1'b1, 32'h4 ^ K, 32'h8);

    // three wait states at address 8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("wait%0d", i), 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    end
    imem_ready = 1'b1;
    tick();
    chk1("f8", 1'b1, 32'hC, 1'b1, 32'h8 ^ K, 32'hC);

    // two-cycle stall holding the word at pcp4=12
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1($sformatf("stall%0d", i), 1'b0, 32'hC, 1'b1, 32'h8 ^ K, 32'hC);
    end
    stall = 1'b0;
    tick();
    chk1("unstall", 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
    tick();
    chk1("fC", 1'b1, 32'h10, 1'b1, 32'hC ^ K, 32'h10);

    // redirect beats stall and completion
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0102;
    stall       = 1'b1;
    tick();
    chk1("redir", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    chk("redir.mis", {31'b0, mis1}, 32'h1);
    redirect_en = 1'b0;
    stall       = 1'b0;
    tick();
    chk1("f100", 1'b1, 32'h104, 1'b1, 32'h100 ^ K, 32'h104);
    chk("mis.sticky", {31'b0, mis1}, 32'h1);

    // redirect during BOOT is ignored
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2.mis", {31'b0, mis1}, 32'h0);
    chk("rst2.ov", {31'b0, ov1}, 32'h0);
    tick();
    rst_n       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    chk("bootredir.addr", addr1, 32'h0);
    chk("bootredir.mis", {31'b0, mis1}, 32'h0);
    redirect_en = 1'b0;

    // wrap instance
    rst2_n = 1'b1;
    tick();
    chk("w.boot.addr", addr2, 32'hFFFF_FFFC);
    chk("w.boot.req", {31'b0, req2}, 32'h1);
    tick();
    chk("w.ins", ins2, 32'hFFFF_FFFC ^ K);
    chk("w.pcp4", pcp42, 32'h0);
    chk("w.ov", {31'b0, ov2}, 32'h1);
    chk("w.addr", addr2, 32'h0);

    // async reset mid-fetch
    imem_ready = 1'b0;
    #3;
    rst2_n = 1'b0;
    #1;
    chk("w.ar.ov", {31'b0, ov2}, 32'h0);
    chk("w.ar.ins", ins2, 32'h0);
    chk("w.ar.pcp4", pcp42, 32'h0);
    chk("w.ar.req", {31'b0, req2}, 32'h0);
    chk("w.ar.addr", addr2, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    tick();
    rst2_n = 1'b1;
    tick();
    chk("w.re.addr", addr2, 32'hFFFF_FFFC);
    chk("w.re.req", {31'b0, req2}, 32'h1);
    tick();
    chk("w.re.ins", ins2, 32'hFFFF_FFFC ^ K);
    chk("w.re.pcp4", pcp42, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset (word-aligned).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port stall  input  1  IF/ID register holding; current fetch output must not change.
REQ-005 SHALL have port redirect_en  input  1  branch/jump taken; load redirect_pc and squash.
REQ-006 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-007 SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 SHALL have port imem_addr  output  32  read address; always equals the internal PC.
REQ-009 SHALL have port imem_ready  input  1  imem_rdata valid this cycle; the read completes when imem_req && imem_ready.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port pcp4  output  32  PC+4 of the instruction on ins, to IF/ID.
REQ-012 SHALL have port ins  output  32  fetched instruction, to IF/ID; 0 (NOP) when out_valid=0.
REQ-013 SHALL have port out_valid  output  1  ins/pcp4 hold a real instruction.
REQ-014 SHALL have port misalign  output  1  sticky flag; a redirect target had bits [1:0] != 0.

Function
REQ-015 SHALL implement FSM states BOOT, FETCH, STALL.
REQ-016 BOOT: imem_req=0; always go to FETCH on the next edge.
REQ-017 FETCH: imem_req=1.
REQ-018 FETCH: on completion with stall=0, register ins<=imem_rdata, pcp4<=pc+4, out_valid<=1, pc<=pc+4, all in that edge (latency 1 cycle from completion).
REQ-019 FETCH: with no completion and stall=0, register a bubble: ins<=0, pcp4<=0, out_valid<=0; pc unchanged.
REQ-020 FETCH with stall=1 and out_valid=1: hold all outputs and pc; ignore any completion; go to STALL.
REQ-021 FETCH with stall=1 and out_valid=0: behaves as stall=0.
REQ-022 STALL: imem_req=0; outputs and pc hold while stall=1.
REQ-023 STALL: when stall=0, out_valid<=0, ins<=0, pcp4<=0 (held word consumed); go to FETCH.
REQ-024 redirect_en=1 SHALL override stall and any completion in any state except BOOT: pc<={redirect_pc[31:2],2'b00}, out_valid<=0, ins<=0, pcp4<=0, next state FETCH.
REQ-025 redirect_en=1 while in BOOT SHALL be ignored.
REQ-026 redirect_en=1 with redirect_pc[1:0]!=0 SHALL set misalign<=1; misalign never clears except by reset.
REQ-027 pc+4 SHALL be 32-bit modulo: pc 32'hFFFF_FFFC fetches, then pc and pcp4 both wrap to 32'h0000_0000.
REQ-028 pc[1:0] SHALL always be 2'b00.

Reset
REQ-029 rst_n=0 SHALL immediately force: state BOOT, pc=RESET_PC, ins=0, pcp4=0, out_valid=0, misalign=0, imem_req=0, independent of clk.
REQ-030 Reset asserted mid-fetch or mid-stall SHALL discard the pending read; the first request after release is at RESET_PC.

Structure
REQ-031 A shared package SHALL hold the state enum (BOOT/FETCH/STALL), the NOP encoding 32'h0, and the word increment constant 4.
REQ-032 One sub-module SHALL be natural: if_pc_reg (PC register with increment/redirect/hold mux); FSM and output register stay in if_fetch.

Verification
REQ-033 Reset release, imem_ready=1 constantly, memory word at A = A^32'hA5A5_0000 -> imem_addr 0,4,8; ins/pcp4 pairs (0^..,4),(4^..,8); out_valid=1 from the 2nd edge after BOOT.
REQ-034 imem_ready low for 3 cycles at addr 8 -> 3 bubbles (out_valid=0, ins=0); imem_addr stays 8; ins for 8 appears the edge after ready rises.
REQ-035 stall=1 for 2 cycles while ins valid at pcp4=12 -> ins/pcp4 constant, imem_req=0; after release, one bubble, then fetch resumes at 12.
REQ-036 redirect_en=1, redirect_pc=32'h0000_0102, simultaneous stall=1 and completion -> next imem_addr 32'h0000_0100, out_valid=0, misalign=1 and stays 1.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first ins pcp4=0, next imem_addr 0; assert rst_n=0 mid-fetch -> outputs zero asynchronously, restart at 32'hFFFF_FFFC.
